// File: rtl/laser_dac_driver.sv
// Point-streaming SPI back end for an MCP4922 dual DAC; the LDAC pulse and the laser colour update land on the same cycle.
// Optional feature: define LASER_IDLE_BLANK_EN to blank the laser after IDLE_TIMEOUT cycles without a latch.
module laser_dac_driver #(
  parameter int CLK_DIV      = 2,
  parameter int CS_GAP       = 2,
  parameter int LATCH_LEN    = 2,
  parameter int IDLE_TIMEOUT = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        point_valid,
  output logic        point_ready,
  input  logic [11:0] point_x,
  input  logic [11:0] point_y,
  input  logic [2:0]  point_rgb,
  output logic        dac_csn,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_latchn,
  output logic [2:0]  laser_rgb,
  output logic        point_done
);

  localparam int CNT_MAX0 = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_MAX  = (CNT_MAX0 > LATCH_LEN) ? CNT_MAX0 : LATCH_LEN;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_LEN - 1);

  if (CLK_DIV < 1)      begin : g_bad_clk_div  $error("CLK_DIV must be >= 1");      end
  if (CS_GAP < 1)       begin : g_bad_cs_gap   $error("CS_GAP must be >= 1");       end
  if (LATCH_LEN < 1)    begin : g_bad_latch    $error("LATCH_LEN must be >= 1");    end
  if (IDLE_TIMEOUT < 1) begin : g_bad_timeout  $error("IDLE_TIMEOUT must be >= 1"); end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_A = 3'd1,
    GAP_A   = 3'd2,
    SHIFT_B = 3'd3,
    GAP_B   = 3'd4,
    LATCH   = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        bit_idx, bit_n;
  logic              phase, phase_n;
  logic              ready_en;

  logic [11:0]       x_q, y_q;
  logic [2:0]        rgb_q;

  logic              accept;
  logic              latch_entry;
  logic              blank;
  logic              shift_n;
  logic [15:0]       word_a, word_b, word;
  logic              csn_n, sclk_n, mosi_n;
  logic [2:0]        rgb_n;

  // ready_en keeps point_ready low through the reset cycles themselves.
  assign point_ready = (state == IDLE) && ready_en;
  assign accept      = point_valid && point_ready;

  // Control bits: channel select, buffered Vref, 1x gain, active.
  assign word_a = {4'b0111, x_q};
  assign word_b = {4'b1111, y_q};

  always_comb begin
    // NOTE: every variable is given a default first so no path through the case infers a latch.
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    phase_n = phase;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT_A;
          cnt_n   = '0;
          bit_n   = '0;
          phase_n = 1'b0;
        end
      end
      SHIFT_A, SHIFT_B: begin
        if (cnt != DIV_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n   = '0;
          phase_n = ~phase;
          if (phase) begin
            if (bit_idx == 4'd15) state_n = (state == SHIFT_A) ? GAP_A : GAP_B;
            else                  bit_n   = bit_idx + 4'd1;
          end
        end
      end
      GAP_A, GAP_B: begin
        if (cnt != GAP_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n   = '0;
          bit_n   = '0;
          phase_n = 1'b0;
          state_n = (state == GAP_A) ? SHIFT_B : LATCH;
        end
      end
      LATCH: begin
        if (cnt != LATCH_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign latch_entry = (state_n == LATCH) && (state != LATCH);

  // Outputs are decoded from the next state and registered, so they line up with the state they belong to.
  always_comb begin
    shift_n = (state_n == SHIFT_A) || (state_n == SHIFT_B);
    word    = (state_n == SHIFT_A) ? word_a : word_b;
    csn_n   = ~shift_n;
    sclk_n  = shift_n & phase_n;
    mosi_n  = shift_n & word[4'd15 - bit_n];
    rgb_n   = laser_rgb;
    if (latch_entry) rgb_n = rgb_q;
    else if (blank)  rgb_n = 3'b000;
  end

`ifdef LASER_IDLE_BLANK_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;

  always_comb begin
    idle_cnt_n = idle_cnt;
    if (latch_entry)            idle_cnt_n = '0;
    else if (idle_cnt != IDLE_SAT) idle_cnt_n = idle_cnt + 1'b1;
  end

  // Blanking is applied on the same edge the counter reaches saturation.
  assign blank = (idle_cnt_n == IDLE_SAT);

  always_ff @(posedge clk) begin
    if (reset) idle_cnt <= '0;
    else       idle_cnt <= idle_cnt_n;
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      phase      <= 1'b0;
      ready_en   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rgb_q      <= '0;
      dac_csn    <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_latchn <= 1'b1;
      laser_rgb  <= 3'b000;
      point_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      phase      <= phase_n;
      ready_en   <= 1'b1;
      if (accept) begin
        x_q   <= point_x;
        y_q   <= point_y;
        rgb_q <= point_rgb;
      end
      dac_csn    <= csn_n;
      dac_sclk   <= sclk_n;
      dac_mosi   <= mosi_n;
      dac_latchn <= (state_n != LATCH);
      laser_rgb  <= rgb_n;
      point_done <= latch_entry;
    end
  end

endmodule
